spi_master_param: RTL and testbench

Parametrised SPI master, successor to the fixed 8-bit, SCK=i_clk shifter. Adds:
- configurable word width
- programmable SCK divider
- all four CPOL/CPHA modes
- MSB/LSB-first ordering
- NUM_CS one-hot-decoded active-low chip selects

It sits between the register/buffer layer and the off-chip SPI pins. It takes one word per i_start and returns the received word with a single-cycle done pulse.

---
 rtl/spi_master_param.sv | 182 ++++++++++++++++++
 tb/tb_spi_master_param.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable width, SCK divider, CPOL/CPHA,
// bit order and one-hot active-low chip selects.
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_CS = 4,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic [CS_W-1:0]   i_cs_sel,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_lsb_first,
    input  logic [DIV_W-1:0]  i_clk_div,
    input  logic              i_spi_miso,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_spi_sck,
    output logic              o_spi_mosi,
    output logic [NUM_CS-1:0] o_spi_cs_n
);

    localparam int EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);
    localparam logic [EW-1:0] FIRST_EDGE = EW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } state_t;

    state_t state, state_n;

    logic              cfg_cpha;
    logic              cfg_lsb;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cnt;
    logic [EW-1:0]     ecnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;

    logic              accept;
    logic              tog;
    logic              fin;
    logic              last;
    logic              lead;
    logic              smp;
    logic              drv;
    logic [EW-1:0]     edge_n;
    logic [NUM_CS-1:0] cs_dec;
    logic [DATA_W-1:0] rx_next;

    assign last    = (cnt == '0);
    assign edge_n  = ecnt + EW'(1);
    assign lead    = edge_n[0];
    assign smp     = tog && (cfg_cpha ? !lead : lead);
    assign drv     = tog && (cfg_cpha ? (lead && edge_n != FIRST_EDGE)
                                      : (!lead && edge_n != LAST_EDGE));
    assign rx_next = cfg_lsb ? {i_spi_miso, rx_sh[DATA_W-1:1]}
                             : {rx_sh[DATA_W-2:0], i_spi_miso};

    // Decode the requested slave; out-of-range indices select nobody
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            cs_dec[i] = (i_cs_sel != CS_W'(i));
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle events from the half-period counter
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        tog     = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    accept  = 1'b1;
                    state_n = LEAD;
                end
            end
            LEAD: begin
                if (last) begin
                    tog     = 1'b1;
                    state_n = XFER;
                end
            end
            XFER: begin
                if (last) begin
                    if (ecnt == LAST_EDGE) begin
                        state_n = TRAIL;
                    end else begin
                        tog = 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (last) begin
                    fin     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: config latch, divider, SCK, shift registers and outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cfg_cpha   <= 1'b0;
            cfg_lsb    <= 1'b0;
            cfg_div    <= '0;
            cnt        <= '0;
            ecnt       <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            o_rx_data  <= '0;
            o_done     <= 1'b0;
            o_busy     <= 1'b0;
            o_spi_sck  <= 1'b0;
            o_spi_mosi <= 1'b0;
            o_spi_cs_n <= '1;
        end else begin
            o_done <= 1'b0;
            if (state == IDLE) begin
                o_spi_sck  <= i_cpol;
                o_spi_mosi <= 1'b0;
            end
            if (accept) begin
                cfg_cpha   <= i_cpha;
                cfg_lsb    <= i_lsb_first;
                cfg_div    <= i_clk_div;
                cnt        <= i_clk_div;
                ecnt       <= '0;
                rx_sh      <= '0;
                o_busy     <= 1'b1;
                o_spi_cs_n <= cs_dec;
                o_spi_mosi <= i_lsb_first ? i_tx_data[0]
                                          : i_tx_data[DATA_W-1];
                tx_sh      <= i_lsb_first ? (i_tx_data >> 1)
                                          : (i_tx_data << 1);
            end else if (state != IDLE) begin
                cnt <= last ? cfg_div : cnt - DIV_W'(1);
            end
            if (tog) begin
                o_spi_sck <= ~o_spi_sck;
                ecnt      <= edge_n;
            end
            if (smp) begin
                rx_sh <= rx_next;
            end
            if (drv) begin
                o_spi_mosi <= cfg_lsb ? tx_sh[0] : tx_sh[DATA_W-1];
                tx_sh      <= cfg_lsb ? (tx_sh >> 1) : (tx_sh << 1);
            end
            if (fin) begin
                o_spi_cs_n <= '1;
                o_busy     <= 1'b0;
                o_done     <= 1'b1;
                o_rx_data  <= rx_sh;
                o_spi_mosi <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed self-checking bench for spi_master_param.
// Two instances: default (NUM_CS=4) and NUM_CS=3 for out-of-range select.
module tb_spi_master_param;

    localparam logic [7:0] SLAVE_WORD = 8'hC3;

    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_tx_data = 8'h00;
    logic [1:0] i_cs_sel = 2'd0;
    logic       i_cpol = 1'b0;
    logic       i_cpha = 1'b0;
    logic       i_lsb_first = 1'b0;
    logic [7:0] i_clk_div = 8'd0;
    logic       miso;
    logic [7:0] o_rx_data;
    logic       o_done;
    logic       o_busy;
    logic       o_spi_sck;
    logic       o_spi_mosi;
    logic [3:0] o_spi_cs_n;

    logic       use_slave = 1'b0;
    logic       slave_miso = 1'b0;
    int         sidx = 7;
    logic       cs0_n;

    logic       b_start = 1'b0;
    logic [7:0] b_tx = 8'h96;
    logic [1:0] b_sel = 2'd3;
    logic [7:0] b_rx;
    logic       b_done;
    logic       b_busy;
    logic       b_sck;
    logic       b_mosi;
    logic [2:0] b_cs_n;

    int n_checks = 0;
    int n_errors = 0;

    int busy_cyc, done_cyc, done_cnt, rises, first_rise;
    int cs_low, cs_bad, mosi_bad, stray;
    logic [7:0] mseq;
    logic [3:0] cs_first;
    logic       p_sck, p_mosi;

    always #5 clk = ~clk;

    assign miso  = use_slave ? slave_miso : o_spi_mosi;
    assign cs0_n = o_spi_cs_n[0];

    // Slave for CPHA=1 transfers on cs 0: shifts MSB-first on leading edge
    always @(negedge o_spi_sck or posedge cs0_n) begin
        if (cs0_n) begin
            sidx <= 7;
        end else begin
            slave_miso <= SLAVE_WORD[sidx[2:0]];
            sidx       <= sidx - 1;
        end
    end

    spi_master_param dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_tx_data   (i_tx_data),
        .i_cs_sel    (i_cs_sel),
        .i_cpol      (i_cpol),
        .i_cpha      (i_cpha),
        .i_lsb_first (i_lsb_first),
        .i_clk_div   (i_clk_div),
        .i_spi_miso  (miso),
        .o_rx_data   (o_rx_data),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_spi_sck   (o_spi_sck),
        .o_spi_mosi  (o_spi_mosi),
        .o_spi_cs_n  (o_spi_cs_n)
    );

    spi_master_param #(.NUM_CS(3)) dut3 (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (b_start),
        .i_tx_data   (b_tx),
        .i_cs_sel    (b_sel),
        .i_cpol      (1'b0),
        .i_cpha      (1'b0),
        .i_lsb_first (1'b0),
        .i_clk_div   (8'd0),
        .i_spi_miso  (b_mosi),
        .o_rx_data   (b_rx),
        .o_done      (b_done),
        .o_busy      (b_busy),
        .o_spi_sck   (b_sck),
        .o_spi_mosi  (b_mosi),
        .o_spi_cs_n  (b_cs_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] tx, input logic [1:0] sel,
                          input logic cpha, input logic lsb,
                          input logic [7:0] div, input logic hold);
        @(negedge clk);
        i_tx_data   = tx;
        i_cs_sel    = sel;
        i_cpha      = cpha;
        i_lsb_first = lsb;
        i_clk_div   = div;
        i_start     = 1'b1;
        p_sck       = o_spi_sck;
        p_mosi      = o_spi_mosi;
        @(posedge clk);
        #1;
        if (!hold) i_start = 1'b0;
    endtask

    task automatic set_cpol(input logic v);
        @(negedge clk);
        i_cpol = v;
        repeat (2) @(negedge clk);
    endtask

    // k counts cycles after the accepting edge (k=1 is cycle T+1)
    task automatic watch(input int budget, input int pulse_k,
                         input logic [3:0] cs_exp, input logic lvl);
        busy_cyc = 0; done_cyc = 0; done_cnt = 0; rises = 0;
        first_rise = 0; cs_low = 0; cs_bad = 0; mosi_bad = 0;
        mseq = 8'h00; cs_first = 4'hF;
        for (int k = 1; k <= budget && done_cnt == 0; k++) begin
            @(negedge clk);
            if (pulse_k > 0) begin
                if (k == pulse_k) i_start = 1'b1;
                else if (k == pulse_k + 1) i_start = 1'b0;
            end
            if (k == 1) cs_first = o_spi_cs_n;
            if (o_busy) busy_cyc++;
            if (o_busy && o_spi_cs_n != cs_exp) cs_bad++;
            if (o_spi_cs_n != 4'hF) cs_low++;
            if (!p_sck && o_spi_sck) begin
                rises++;
                if (first_rise == 0) first_rise = k;
            end
            if (p_sck != o_spi_sck && o_spi_sck == lvl)
                mseq = {mseq[6:0], p_mosi};
            if (k >= 2 && o_busy && o_spi_mosi != p_mosi &&
                !(p_sck && !o_spi_sck))
                mosi_bad++;
            if (o_done) begin
                done_cnt++;
                done_cyc = k;
            end
            p_sck  = o_spi_sck;
            p_mosi = o_spi_mosi;
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", o_spi_cs_n, 4'hF);
        chk("rst_sck", o_spi_sck, 0);
        chk("rst_mosi", o_spi_mosi, 0);
        chk("rst_rx", o_rx_data, 8'h00);
        chk("rst_done", o_done, 0);
        chk("rst_busy", o_busy, 0);
        i_rst = 1'b1;
        repeat (2) @(negedge clk);

        // mode 0, div 0, MSB-first, loopback 0xA5
        launch(8'hA5, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        watch(40, 0, 4'b1110, 1'b1);
        chk("m0_done_cnt", done_cnt, 1);
        chk("m0_done_cyc", done_cyc, 19);
        chk("m0_busy", busy_cyc, 18);
        chk("m0_rx", o_rx_data, 8'hA5);
        chk("m0_rises", rises, 8);
        chk("m0_first_rise", first_rise, 2);
        chk("m0_cs_low", cs_low, 18);
        chk("m0_cs_bad", cs_bad, 0);
        chk("m0_mosi_seq", mseq, 8'hA5);

        // mode 3, div 3, slave returns 0xC3
        set_cpol(1'b1);
        chk("m3_sck_idle", o_spi_sck, 1);
        use_slave = 1'b1;
        launch(8'h3C, 2'd0, 1'b1, 1'b0, 8'd3, 1'b0);
        watch(120, 0, 4'b1110, 1'b1);
        use_slave = 1'b0;
        chk("m3_done_cnt", done_cnt, 1);
        chk("m3_busy", busy_cyc, 72);
        chk("m3_done_cyc", done_cyc, 73);
        chk("m3_rx", o_rx_data, 8'hC3);
        chk("m3_mosi_on_fall", mosi_bad, 0);
        chk("m3_mosi_seq", mseq, 8'h3C);
        chk("m3_rises", rises, 8);
        @(negedge clk);
        chk("m3_sck_after", o_spi_sck, 1);

        // mode 1, LSB-first, tx 0x01
        set_cpol(1'b0);
        launch(8'h01, 2'd0, 1'b1, 1'b1, 8'd0, 1'b0);
        watch(40, 0, 4'b1110, 1'b0);
        chk("m1_done_cyc", done_cyc, 19);
        chk("m1_mosi_seq", mseq, 8'h80);
        chk("m1_rx", o_rx_data, 8'h01);

        // cs_sel 2 with an ignored start pulse at T+5
        launch(8'h3C, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
        watch(40, 5, 4'b1011, 1'b1);
        chk("cs2_cs_bad", cs_bad, 0);
        chk("cs2_cs_low", cs_low, 18);
        chk("cs2_done_cnt", done_cnt, 1);
        chk("cs2_done_cyc", done_cyc, 19);
        chk("cs2_rx", o_rx_data, 8'h3C);
        stray = 0;
        repeat (25) begin
            @(negedge clk);
            if (o_busy || o_done || o_spi_cs_n != 4'hF) stray++;
        end
        chk("cs2_no_requeue", stray, 0);

        // back-to-back with start held through o_done
        launch(8'h81, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1);
        i_tx_data = 8'h42;
        watch(40, 0, 4'b1110, 1'b1);
        chk("b2b_done1_cyc", done_cyc, 19);
        chk("b2b_rx1", o_rx_data, 8'h81);
        chk("b2b_cs_gap", o_spi_cs_n, 4'hF);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        watch(40, 0, 4'b1110, 1'b1);
        chk("b2b_cs_first", cs_first, 4'b1110);
        chk("b2b_done2_cyc", done_cyc, 19);
        chk("b2b_rx2", o_rx_data, 8'h42);

        // reset at T+10 of a div=1 transfer
        launch(8'hF0, 2'd0, 1'b0, 1'b0, 8'd1, 1'b0);
        repeat (10) @(negedge clk);
        chk("ar_busy_before", o_busy, 1);
        i_rst = 1'b0;
        #1;
        chk("ar_cs_n", o_spi_cs_n, 4'hF);
        chk("ar_busy", o_busy, 0);
        chk("ar_mosi", o_spi_mosi, 0);
        chk("ar_sck", o_spi_sck, 0);
        chk("ar_rx", o_rx_data, 8'h00);
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_done) stray++;
        end
        i_rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (o_done || o_busy) stray++;
        end
        chk("ar_no_done", stray, 0);
        launch(8'h5A, 2'd0, 1'b0, 1'b0, 8'd1, 1'b0);
        watch(60, 0, 4'b1110, 1'b1);
        chk("ar_fresh_cyc", done_cyc, 37);
        chk("ar_fresh_rx", o_rx_data, 8'h5A);

        // maximum divider: H = 256
        launch(8'h69, 2'd1, 1'b0, 1'b0, 8'hFF, 1'b0);
        watch(5000, 0, 4'b1101, 1'b1);
        chk("max_done_cyc", done_cyc, 4609);
        chk("max_busy", busy_cyc, 4608);
        chk("max_rx", o_rx_data, 8'h69);

        // NUM_CS=3 instance, cs_sel=3 selects nobody
        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        done_cnt = 0; done_cyc = 0; cs_low = 0; busy_cyc = 0; rises = 0;
        p_sck = b_sck;
        for (int k = 1; k <= 40 && done_cnt == 0; k++) begin
            @(negedge clk);
            if (b_cs_n != 3'b111) cs_low++;
            if (b_busy) busy_cyc++;
            if (!p_sck && b_sck) rises++;
            p_sck = b_sck;
            if (b_done) begin
                done_cnt++;
                done_cyc = k;
            end
        end
        chk("cs3_done_cnt", done_cnt, 1);
        chk("cs3_done_cyc", done_cyc, 19);
        chk("cs3_no_cs", cs_low, 0);
        chk("cs3_busy", busy_cyc, 18);
        chk("cs3_rises", rises, 8);
        chk("cs3_rx", b_rx, 8'h96);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
